// File: rtl/alu_muldiv.sv
// alu_muldiv: execute-stage ALU with an iterative multiply/divide unit and
// architectural HI/LO registers.
//
// Handshake: start is sampled only while the unit is idle (busy=0), and that
// includes the cycle in which done is high. An accepted multiply/divide raises
// busy after that edge, holds it for WIDTH+1 cycles, and then drops it while
// done pulses for exactly one cycle. HI/LO already hold the new result in that
// done cycle. start while busy=1 is dropped, not queued. MTHI/MTLO with start
// in idle write A into HI/LO at the edge and never raise busy.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUControl,
    input  logic             start,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Overflow,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [1:0]       dbg_state
);

    localparam logic [4:0] OP_AND   = 5'b00000;
    localparam logic [4:0] OP_OR    = 5'b00001;
    localparam logic [4:0] OP_ADD   = 5'b00010;
    localparam logic [4:0] OP_SUB   = 5'b00110;
    localparam logic [4:0] OP_SLT   = 5'b00111;
    localparam logic [4:0] OP_SLL   = 5'b01000;
    localparam logic [4:0] OP_SRL   = 5'b01001;
    localparam logic [4:0] OP_SRA   = 5'b01010;
    localparam logic [4:0] OP_SLTU  = 5'b01011;
    localparam logic [4:0] OP_NOR   = 5'b01100;
    localparam logic [4:0] OP_XOR   = 5'b01101;
    localparam logic [4:0] OP_MFHI  = 5'b10100;
    localparam logic [4:0] OP_MFLO  = 5'b10101;
    localparam logic [4:0] OP_MTHI  = 5'b10110;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   load, step, finish;

    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [2*WIDTH-1:0] p_q;        // product, or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   m_q;        // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;
    logic               neg_lo_q;   // negate product / quotient at FIX
    logic               neg_hi_q;   // negate remainder at FIX
    logic               done_q;

    // ---------------- single-cycle ALU ----------------
    logic [WIDTH-1:0]   sum, diff;
    logic [CNT_W-2:0]   shamt;
    logic [WIDTH-1:0]   result;
    logic               ovf;

    assign sum   = A + B;
    assign diff  = A - B;
    assign shamt = B[CNT_W-2:0];

    // Combinational result and overflow for every ALUControl encoding
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (ALUControl)
            OP_AND:  result = A & B;
            OP_OR:   result = A | B;
            OP_NOR:  result = ~(A | B);
            OP_XOR:  result = A ^ B;
            OP_ADD: begin
                result = sum;
                ovf    = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  result = A << shamt;
            OP_SRL:  result = A >> shamt;
            OP_SRA:  result = $unsigned($signed(A) >>> shamt);
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = '0;
        endcase
    end

    assign ALUResult = result;
    assign Overflow  = ovf;
    assign Zero      = (result == '0);

    // ---------------- multiply/divide control ----------------
    logic is_md, is_signed, is_div;
    logic a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic mthi_we, mtlo_we;

    assign is_md     = (ALUControl[4:2] == 3'b100);
    assign is_signed = ~ALUControl[0];
    assign is_div    = ALUControl[1];
    assign a_neg     = is_signed & A[WIDTH-1];
    assign b_neg     = is_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;
    assign mthi_we   = start && (state_q == IDLE) && (ALUControl == OP_MTHI);
    assign mtlo_we   = start && (state_q == IDLE) && (ALUControl == OP_MTLO);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state and datapath strobes
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && is_md) begin
                    state_d = RUN;
                    load    = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_ONE) state_d = FIX;
            end
            FIX: begin
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- iteration datapath ----------------
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic [2*WIDTH-1:0] div_next;

    // One shift-add multiply step and one restoring divide step
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
        mul_next  = {mul_sum, p_q[WIDTH-1:1]};
        rem_shift = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, m_q};
        if (rem_diff[WIDTH]) div_next = {rem_shift[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
        else                 div_next = {rem_diff[WIDTH-1:0],  p_q[WIDTH-2:0], 1'b1};
    end

    // Operand latch at start, then one iteration per RUN cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_q      <= '0;
            m_q      <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else if (load) begin
            cnt_q <= CNT_INIT;
            div_q <= is_div;
            if (is_div) begin
                p_q      <= {{WIDTH{1'b0}}, a_mag};
                m_q      <= b_mag;
                // Divide by zero keeps the raw all-ones quotient.
                neg_lo_q <= (a_neg ^ b_neg) & (B != '0);
                neg_hi_q <= a_neg;
            end else begin
                p_q      <= {{WIDTH{1'b0}}, b_mag};
                m_q      <= a_mag;
                neg_lo_q <= a_neg ^ b_neg;
                neg_hi_q <= 1'b0;
            end
        end else if (step) begin
            cnt_q <= cnt_q - CNT_ONE;
            p_q   <= div_q ? div_next : mul_next;
        end
    end

    // ---------------- sign correction and HI/LO ----------------
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix, lo_fix;

    // Final sign fix: whole product, or quotient and remainder separately
    always_comb begin
        prod_fix = neg_lo_q ? -p_q : p_q;
        if (div_q) begin
            hi_fix = neg_hi_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
            lo_fix = neg_lo_q ? -p_q[WIDTH-1:0]       : p_q[WIDTH-1:0];
        end else begin
            hi_fix = prod_fix[2*WIDTH-1:WIDTH];
            lo_fix = prod_fix[WIDTH-1:0];
        end
    end

    // HI/LO architectural registers and done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish) begin
                hi_q <= hi_fix;
                lo_q <= lo_fix;
            end else begin
                if (mthi_we) hi_q <= A;
                if (mtlo_we) lo_q <= A;
            end
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign stall     = busy & ALUControl[4];
    assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for the single-cycle ALU and the
// multiply/divide unit of alu_muldiv (WIDTH=32).
module tb_alu_muldiv;

  localparam int W = 32;

  localparam logic [4:0] OP_AND   = 5'b00000;
  localparam logic [4:0] OP_OR    = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00110;
  localparam logic [4:0] OP_SLT   = 5'b00111;
  localparam logic [4:0] OP_SLL   = 5'b01000;
  localparam logic [4:0] OP_SRL   = 5'b01001;
  localparam logic [4:0] OP_SRA   = 5'b01010;
  localparam logic [4:0] OP_SLTU  = 5'b01011;
  localparam logic [4:0] OP_NOR   = 5'b01100;
  localparam logic [4:0] OP_XOR   = 5'b01101;
  localparam logic [4:0] OP_MULT  = 5'b10000;
  localparam logic [4:0] OP_MULTU = 5'b10001;
  localparam logic [4:0] OP_DIV   = 5'b10010;
  localparam logic [4:0] OP_DIVU  = 5'b10011;
  localparam logic [4:0] OP_MFHI  = 5'b10100;
  localparam logic [4:0] OP_MFLO  = 5'b10101;
  localparam logic [4:0] OP_MTHI  = 5'b10110;
  localparam logic [4:0] OP_MTLO  = 5'b10111;

  localparam int LAT = W + 1;

  logic         clk;
  logic         reset;
  logic [W-1:0] A, B;
  logic [4:0]   ALUControl;
  logic         start;
  logic [W-1:0] ALUResult;
  logic         Zero, Overflow, busy, done, stall;
  logic [1:0]   dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int e0      = 0;

  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [4:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [4:0]   ctrl;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } md_t;

  vec_t vecs[20];
  md_t  mds[13];

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUControl(ALUControl),
    .start(start), .ALUResult(ALUResult), .Zero(Zero), .Overflow(Overflow),
    .busy(busy), .done(done), .stall(stall), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checkers ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  // Called in the low clock phase; returns in the low phase just after E0.
  task automatic launch(input string name, input logic [4:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b);
    ALUControl = op;
    A          = a;
    B          = b;
    start      = 1'b1;
    @(negedge clk);
    e0    = cyc;
    start = 1'b0;
    check_bit({name, " busy after start"}, busy, 1'b1);
    check_bit({name, " done low after start"}, done, 1'b0);
  endtask

  // Waits (bounded) for done and checks the latency measured from E0.
  task automatic wait_done(input string name);
    while (done !== 1'b1 && (cyc - e0) < 100) @(negedge clk);
    check_int({name, " latency"}, cyc - e0, LAT);
    check_bit({name, " busy low at done"}, busy, 1'b0);
  endtask

  // Reads HI/LO through MFHI/MFLO and compares with the scoreboard.
  task automatic check_hilo(input string name);
    logic [W-1:0] eh, el;
    if (exp_q.size() < 2) begin
      check_int({name, " scoreboard depth"}, exp_q.size(), 2);
    end else begin
      eh = exp_q.pop_front();
      el = exp_q.pop_front();
      ALUControl = OP_MFHI;
      #1 check({name, " HI"}, ALUResult, eh);
      ALUControl = OP_MFLO;
      #1 check({name, " LO"}, ALUResult, el);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int bad;
    int pulses;

    vecs[0]  = '{OP_ADD,  32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{OP_ADD,  32'h00000005, 32'h00000003, 32'h00000008, 1'b0, 1'b0};
    vecs[2]  = '{OP_ADD,  32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[3]  = '{OP_ADD,  32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    vecs[4]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    vecs[5]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b1};
    vecs[6]  = '{OP_SUB,  32'h00000003, 32'h00000005, 32'hfffffffe, 1'b0, 1'b0};
    vecs[7]  = '{OP_AND,  32'hf0f0f0f0, 32'h0ff00ff0, 32'h00f000f0, 1'b0, 1'b0};
    vecs[8]  = '{OP_OR,   32'h00000f00, 32'h000000f0, 32'h00000ff0, 1'b0, 1'b0};
    vecs[9]  = '{OP_NOR,  32'h00000000, 32'h00000000, 32'hffffffff, 1'b0, 1'b0};
    vecs[10] = '{OP_XOR,  32'hffff0000, 32'h0ff00ff0, 32'hf00f0ff0, 1'b0, 1'b0};
    vecs[11] = '{OP_SLT,  32'hffffffff, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    vecs[12] = '{OP_SLTU, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    vecs[13] = '{OP_SLT,  32'h00000001, 32'hffffffff, 32'h00000000, 1'b1, 1'b0};
    vecs[14] = '{OP_SLL,  32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, 1'b0};
    vecs[15] = '{OP_SLL,  32'h00000003, 32'h00000024, 32'h00000030, 1'b0, 1'b0};
    vecs[16] = '{OP_SRL,  32'h80000000, 32'h00000004, 32'h08000000, 1'b0, 1'b0};
    vecs[17] = '{OP_SRA,  32'h80000000, 32'h00000004, 32'hf8000000, 1'b0, 1'b0};
    vecs[18] = '{OP_SUB,  32'h7fffffff, 32'hffffffff, 32'h80000000, 1'b0, 1'b1};
    vecs[19] = '{5'b11111, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0};

    mds[0]  = '{OP_MULT,  32'hfffffffd, 32'h00000007, 32'hffffffff, 32'hffffffeb};
    mds[1]  = '{OP_MULTU, 32'hffffffff, 32'h00000002, 32'h00000001, 32'hfffffffe};
    mds[2]  = '{OP_DIV,   32'hfffffff9, 32'h00000002, 32'hffffffff, 32'hfffffffd};
    mds[3]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hffffffff};
    mds[4]  = '{OP_DIV,   32'h80000000, 32'hffffffff, 32'h00000000, 32'h80000000};
    mds[5]  = '{OP_DIV,   32'hfffffff9, 32'h00000000, 32'hfffffff9, 32'hffffffff};
    mds[6]  = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000e};
    mds[7]  = '{OP_DIV,   32'h00000007, 32'hfffffffe, 32'h00000001, 32'hfffffffd};
    mds[8]  = '{OP_MULT,  32'hffffffff, 32'hffffffff, 32'h00000000, 32'h00000001};
    mds[9]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    mds[10] = '{OP_MULTU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 32'h00000001};
    mds[11] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    mds[12] = '{OP_DIVU,  32'hffffffff, 32'h00000010, 32'h0000000f, 32'h0fffffff};

    reset      = 1'b1;
    start      = 1'b0;
    A          = '0;
    B          = '0;
    ALUControl = OP_AND;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check_bit("reset busy", busy, 1'b0);
    check_bit("reset done", done, 1'b0);
    check("reset state", {30'b0, dbg_state}, 32'h0);
    ALUControl = OP_MFHI;
    #1 check("reset HI", ALUResult, 32'h0);
    check_bit("reset stall", stall, 1'b0);
    ALUControl = OP_MFLO;
    #1 check("reset LO", ALUResult, 32'h0);

    // Single-cycle vectors
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ALUControl = vecs[i].ctrl;
      A          = vecs[i].a;
      B          = vecs[i].b;
      #1;
      check($sformatf("vec%0d result", i), ALUResult, vecs[i].res);
      check_bit($sformatf("vec%0d zero", i), Zero, vecs[i].zero);
      check_bit($sformatf("vec%0d overflow", i), Overflow, vecs[i].ovf);
    end

    // Multi-cycle vectors; each launch lands in the previous done cycle,
    // so the whole table also runs back-to-back.
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(mds[i].hi);
      exp_q.push_back(mds[i].lo);
      launch($sformatf("md%0d", i), mds[i].ctrl, mds[i].a, mds[i].b);
      wait_done($sformatf("md%0d", i));
      check_hilo($sformatf("md%0d", i));
    end

    // MFLO waits on stall; ADD in flight is not stalled; operand changes ignored
    exp_q.push_back(32'h0);
    exp_q.push_back(32'd30);
    launch("stall", OP_MULTU, 32'd5, 32'd6);
    ALUControl = OP_MFLO;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      #1 if (stall !== 1'b1) bad++;
      @(negedge clk);
    end
    check_int("stall MFLO while busy", bad, 0);
    ALUControl = OP_ADD;
    A          = 32'd2;
    B          = 32'd3;
    #1;
    check_bit("stall ADD while busy", stall, 1'b0);
    check("ADD result while busy", ALUResult, 32'd5);
    ALUControl = OP_MFLO;
    #1 check_bit("stall MFLO while busy late", stall, 1'b1);
    wait_done("stall");
    #1 check_bit("stall low at done", stall, 1'b0);
    check_hilo("stall");

    // start while busy is dropped
    exp_q.push_back(32'h0);
    exp_q.push_back(32'd12);
    @(negedge clk);
    launch("ignore", OP_MULTU, 32'd3, 32'd4);
    repeat (5) @(negedge clk);
    ALUControl = OP_DIVU;
    A          = 32'd100;
    B          = 32'd7;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    check_hilo("ignore");
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check_int("ignore no second op", pulses, 0);
    ALUControl = OP_MFLO;
    #1 check("ignore LO held", ALUResult, 32'd12);

    // MTHI / MTLO
    @(negedge clk);
    ALUControl = OP_MTHI;
    A          = 32'hdeadbeef;
    start      = 1'b1;
    @(negedge clk);
    ALUControl = OP_MTLO;
    A          = 32'hcafef00d;
    @(negedge clk);
    start = 1'b0;
    check_bit("mt busy", busy, 1'b0);
    ALUControl = OP_MFHI;
    #1 check("MTHI", ALUResult, 32'hdeadbeef);
    ALUControl = OP_MFLO;
    #1 check("MTLO", ALUResult, 32'hcafef00d);

    // Asynchronous reset mid-RUN
    @(negedge clk);
    launch("reset run", OP_MULTU, 32'hffffffff, 32'hffffffff);
    repeat (10) @(negedge clk);
    check("reset run state", {30'b0, dbg_state}, 32'h1);
    ALUControl = OP_MFHI;
    reset      = 1'b1;
    #1;
    check_bit("async reset busy", busy, 1'b0);
    check_bit("async reset done", done, 1'b0);
    check("async reset HI", ALUResult, 32'h0);
    ALUControl = OP_MFLO;
    #1 check("async reset LO", ALUResult, 32'h0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    check_int("no late done after reset", pulses, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
